// File: rtl/ps2_mouse_event_stream.sv
// ps2_mouse_event_stream
//   Converts decoded PS/2 mouse state plus keyboard modifiers into terminal
//   mouse-event frames and streams them one byte at a time on a valid/ready
//   port. Events are classified as press, release, motion or wheel against the
//   last accepted pointer state. They are filtered by reporting mode and held
//   in a one-entry coalescing slot. Motion-only frames are rate limited.
//
//   Frame layout: PREFIX, X (1 or 2 bytes), Y (1 or 2 bytes), MOD, EVT.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   mouse_control [1:0]   0 off, 1 buttons+wheel, 2 +drag motion, 3 +all motion
//   keyboard_shift/alt/ctrl/meta   modifier levels, sampled with the strobe
//   mouse_state_ready     one-cycle strobe, all mouse inputs valid
//   button_left/middle/right       button levels
//   wheel_up, wheel_down  wheel step flags, only meaningful with the strobe
//   x_text, y_text        pointer column / row
//   out_data, out_valid, out_ready  byte stream towards the host TX path
//   busy                  frame in flight or pending slot occupied
//   event_dropped         one-cycle pulse when a button/wheel event is lost
module ps2_mouse_event_stream #(
  parameter int         X_WIDTH    = 7,
  parameter int         Y_WIDTH    = 6,
  parameter logic [7:0] PREFIX     = 8'h1E,
  parameter int         MOTION_GAP = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mouse_control,
  input  logic               keyboard_shift,
  input  logic               keyboard_alt,
  input  logic               keyboard_ctrl,
  input  logic               keyboard_meta,
  input  logic               mouse_state_ready,
  input  logic               button_left,
  input  logic               button_middle,
  input  logic               button_right,
  input  logic               wheel_up,
  input  logic               wheel_down,
  input  logic [X_WIDTH-1:0] x_text,
  input  logic [Y_WIDTH-1:0] y_text,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               event_dropped
);

  localparam int XB        = (X_WIDTH > 7) ? 2 : 1;
  localparam int YB        = (Y_WIDTH > 7) ? 2 : 1;
  localparam int FRAME_LEN = 3 + XB + YB;
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);
  localparam int GW        = $clog2(MOTION_GAP + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(MOTION_GAP);

  localparam logic [1:0] KIND_PRESS   = 2'd0;
  localparam logic [1:0] KIND_RELEASE = 2'd1;
  localparam logic [1:0] KIND_MOTION  = 2'd2;
  localparam logic [1:0] KIND_WHEEL   = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Two 7-bit groups, most significant first, each tagged with a set MSB.
  // The one-byte form is simply the low group of the same encoding.
  function automatic logic [15:0] coord_enc(input logic [13:0] v);
    return {1'b1, v[13:7], 1'b1, v[6:0]};
  endfunction

  state_t state_r, state_next_s;

  // Reference state (last accepted event)
  logic [2:0]         ref_btn_r;
  logic [X_WIDTH-1:0] ref_x_r;
  logic [Y_WIDTH-1:0] ref_y_r;
  logic               force_report_r;

  // Pending slot
  logic               pend_valid_r;
  logic [1:0]         pend_kind_r;
  logic [1:0]         pend_wheel_r;   // {down, up}
  logic [2:0]         pend_btn_r;     // {middle, right, left}
  logic [3:0]         pend_mod_r;     // {meta, alt, ctrl, shift}
  logic [X_WIDTH-1:0] pend_x_r;
  logic [Y_WIDTH-1:0] pend_y_r;

  // Transmit side
  logic [7:0]         buf_r [0:6];
  logic [2:0]         idx_r;
  logic [7:0]         out_data_r;
  logic               out_valid_r;
  logic               busy_r;
  logic               event_dropped_r;
  logic [GW-1:0]      gap_r;

  // Combinational helpers
  logic               mode_on_s;
  logic [2:0]         btn_s;
  logic               pressed_s;
  logic               released_s;
  logic               moved_s;
  logic               motion_ok_s;
  logic [1:0]         new_kind_s;
  logic               new_evt_s;
  logic               qual_s;
  logic               slot_prio_s;
  logic               accept_s;
  logic               drop_s;
  logic               gap_met_s;
  logic               load_s;
  logic               pend_next_s;
  logic [15:0]        x_enc_s;
  logic [15:0]        y_enc_s;
  logic [7:0]         full_s  [0:6];
  logic [7:0]         frame_s [0:6];
  logic [2:0]         pos_s;

  assign out_data      = out_data_r;
  assign out_valid     = out_valid_r;
  assign busy          = busy_r;
  assign event_dropped = event_dropped_r;

  // Event classification of the current sample against the reference state
  always_comb begin
    mode_on_s   = (mouse_control != 2'd0);
    btn_s       = {button_middle, button_right, button_left};
    pressed_s   = |(btn_s & ~ref_btn_r);
    released_s  = |(~btn_s & ref_btn_r);
    moved_s     = (x_text != ref_x_r) || (y_text != ref_y_r) || force_report_r;
    motion_ok_s = (mouse_control == 2'd3) || ((mouse_control == 2'd2) && (|btn_s));
    new_kind_s  = KIND_MOTION;
    new_evt_s   = 1'b0;
    if (wheel_up || wheel_down) begin
      new_kind_s = KIND_WHEEL;
      new_evt_s  = 1'b1;
    end else if (pressed_s) begin
      new_kind_s = KIND_PRESS;
      new_evt_s  = 1'b1;
    end else if (released_s) begin
      new_kind_s = KIND_RELEASE;
      new_evt_s  = 1'b1;
    end else if (moved_s) begin
      // Motion outside its mode is ignored entirely, reference untouched.
      new_kind_s = KIND_MOTION;
      new_evt_s  = motion_ok_s;
    end else begin
      new_kind_s = KIND_MOTION;
      new_evt_s  = 1'b0;
    end
  end

  // Slot arbitration; a same-cycle load empties the slot before the new sample lands
  always_comb begin
    gap_met_s   = (gap_r == GAP_MAX);
    load_s      = (state_r == ST_IDLE) && mode_on_s && pend_valid_r &&
                  ((pend_kind_r != KIND_MOTION) || gap_met_s);
    qual_s      = mouse_state_ready && mode_on_s && new_evt_s;
    slot_prio_s = pend_valid_r && !load_s && (pend_kind_r != KIND_MOTION);
    accept_s    = qual_s && !slot_prio_s;
    drop_s      = qual_s && slot_prio_s && (new_kind_s != KIND_MOTION);
    if (!mode_on_s) begin
      pend_next_s = 1'b0;
    end else if (accept_s) begin
      pend_next_s = 1'b1;
    end else if (load_s) begin
      pend_next_s = 1'b0;
    end else begin
      pend_next_s = pend_valid_r;
    end
  end

  // Frame assembly from the pending slot, squeezing out unused high coord bytes
  always_comb begin
    x_enc_s  = coord_enc(14'(pend_x_r));
    y_enc_s  = coord_enc(14'(pend_y_r));
    full_s[0] = PREFIX;
    full_s[1] = x_enc_s[15:8];
    full_s[2] = x_enc_s[7:0];
    full_s[3] = y_enc_s[15:8];
    full_s[4] = y_enc_s[7:0];
    full_s[5] = {1'b1, pend_mod_r, pend_btn_r};
    full_s[6] = {1'b1, 3'b000, pend_wheel_r, pend_kind_r};
    pos_s = 3'd0;
    for (int k = 0; k < 7; k++) begin
      frame_s[k] = 8'h00;
    end
    for (int i = 0; i < 7; i++) begin
      if (((i == 1) && (XB == 1)) || ((i == 3) && (YB == 1))) begin
        pos_s = pos_s;
      end else begin
        frame_s[pos_s] = full_s[i];
        pos_s = pos_s + 3'd1;
      end
    end
  end

  // Next-state logic of the transmit FSM
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_s) begin
          state_next_s = ST_SEND;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (out_ready && (idx_r == LAST_IDX)) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_SEND;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Shift buffer and registered byte output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 7; k++) begin
        buf_r[k] <= 8'h00;
      end
      idx_r       <= 3'd0;
      out_data_r  <= 8'h00;
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      for (int k = 0; k < 7; k++) begin
        buf_r[k] <= frame_s[k];
      end
      idx_r       <= 3'd0;
      out_data_r  <= frame_s[0];
      out_valid_r <= 1'b1;
    end else if ((state_r == ST_SEND) && out_ready) begin
      if (idx_r == LAST_IDX) begin
        idx_r       <= 3'd0;
        out_valid_r <= 1'b0;
      end else begin
        idx_r      <= idx_r + 3'd1;
        out_data_r <= buf_r[idx_r + 3'd1];
      end
    end
  end

  // Pending slot, reference state and force_report
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid_r   <= 1'b0;
      pend_kind_r    <= 2'd0;
      pend_wheel_r   <= 2'd0;
      pend_btn_r     <= 3'd0;
      pend_mod_r     <= 4'd0;
      pend_x_r       <= {X_WIDTH{1'b0}};
      pend_y_r       <= {Y_WIDTH{1'b0}};
      ref_btn_r      <= 3'd0;
      ref_x_r        <= {X_WIDTH{1'b0}};
      ref_y_r        <= {Y_WIDTH{1'b0}};
      force_report_r <= 1'b1;
    end else if (!mode_on_s) begin
      pend_valid_r   <= 1'b0;
      force_report_r <= 1'b1;
    end else begin
      pend_valid_r <= pend_next_s;
      if (accept_s) begin
        pend_kind_r    <= new_kind_s;
        pend_wheel_r   <= {wheel_down, wheel_up};
        pend_btn_r     <= btn_s;
        pend_mod_r     <= {keyboard_meta, keyboard_alt, keyboard_ctrl, keyboard_shift};
        pend_x_r       <= x_text;
        pend_y_r       <= y_text;
        ref_btn_r      <= btn_s;
        ref_x_r        <= x_text;
        ref_y_r        <= y_text;
        force_report_r <= 1'b0;
      end
    end
  end

  // Motion rate limiter: cycles since the last frame load, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_r <= GAP_MAX;
    end else if (load_s) begin
      gap_r <= {GW{1'b0}};
    end else if (!gap_met_s) begin
      gap_r <= gap_r + GW'(1);
    end
  end

  // Registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r          <= 1'b0;
      event_dropped_r <= 1'b0;
    end else begin
      busy_r          <= (state_next_s == ST_SEND) || pend_next_s;
      event_dropped_r <= drop_s;
    end
  end

endmodule
